// File: rtl/button_debouncer.sv
// Push-button synchroniser/debouncer with registered level, press/release strobes and press counter.
// Optional long-press strobe is built when BUTTON_LONG_PRESS_EN is defined.
module button_debouncer #(
    parameter int CLK_HZ      = 27_000_000,
    parameter int DEBOUNCE_MS = 10,
    parameter int LONG_MS     = 1000,
    parameter int ACTIVE_LOW  = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       btn,
    output logic       pressed,
    output logic       press_pulse,
    output logic       release_pulse,
    output logic       long_pulse,
    output logic [7:0] press_count
);

    localparam int DB_CYCLES   = (CLK_HZ / 1000) * DEBOUNCE_MS;
    localparam int LONG_CYCLES = (CLK_HZ / 1000) * LONG_MS;
    localparam int CW          = $clog2(LONG_CYCLES + 1);

    localparam logic [CW-1:0] DB_MAX   = CW'(DB_CYCLES);
    localparam logic [CW-1:0] LONG_MAX = CW'(LONG_CYCLES);
    localparam logic          IDLE_LVL = (ACTIVE_LOW != 0) ? 1'b1 : 1'b0;

    typedef enum logic [1:0] {
        IDLE,
        PRESS_WAIT,
        DOWN,
        RELEASE_WAIT
    } state_t;

    state_t        state, state_n;
    logic          s1, s2, act;
    logic [CW-1:0] cnt, cnt_n;
    logic          pressed_n, press_pulse_n, release_pulse_n;
    logic [7:0]    press_count_n;

    assign act = (ACTIVE_LOW != 0) ? ~s2 : s2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1            <= IDLE_LVL;
            s2            <= IDLE_LVL;
            state         <= IDLE;
            cnt           <= '0;
            pressed       <= 1'b0;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            press_count   <= '0;
        end else begin
            s1            <= btn;
            s2            <= s1;
            state         <= state_n;
            cnt           <= cnt_n;
            pressed       <= pressed_n;
            press_pulse   <= press_pulse_n;
            release_pulse <= release_pulse_n;
            press_count   <= press_count_n;
        end
    end

    always_comb begin
        state_n         = state;
        cnt_n           = cnt;
        pressed_n       = pressed;
        press_pulse_n   = 1'b0;
        release_pulse_n = 1'b0;
        press_count_n   = press_count;
        unique case (state)
            IDLE: begin
                if (act) begin
                    state_n = PRESS_WAIT;
                    cnt_n   = CW'(1);
                end
            end
            PRESS_WAIT: begin
                if (!act) begin
                    state_n = IDLE;
                    cnt_n   = '0;
                end else if (cnt == DB_MAX) begin
                    state_n       = DOWN;
                    cnt_n         = '0;
                    press_pulse_n = 1'b1;
                    pressed_n     = 1'b1;
                    press_count_n = press_count + 8'd1;
                end else if (cnt != LONG_MAX) begin
                    cnt_n = cnt + 1'b1;
                end
            end
            DOWN: begin
                if (!act) begin
                    state_n = RELEASE_WAIT;
                    cnt_n   = CW'(1);
                end
            end
            RELEASE_WAIT: begin
                if (act) begin
                    state_n = DOWN;
                    cnt_n   = '0;
                end else if (cnt == DB_MAX) begin
                    state_n         = IDLE;
                    cnt_n           = '0;
                    release_pulse_n = 1'b1;
                    pressed_n       = 1'b0;
                end else if (cnt != LONG_MAX) begin
                    cnt_n = cnt + 1'b1;
                end
            end
            default: begin
                state_n = IDLE;
                cnt_n   = '0;
            end
        endcase
    end

`ifdef BUTTON_LONG_PRESS_EN
    logic [CW-1:0] lcnt, lcnt_n;
    logic          long_n;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lcnt       <= '0;
            long_pulse <= 1'b0;
        end else begin
            lcnt       <= lcnt_n;
            long_pulse <= long_n;
        end
    end

    // Restart only on an accepted press; a short release bounce keeps the hold time.
    always_comb begin
        lcnt_n = lcnt;
        long_n = 1'b0;
        if (press_pulse_n || state_n == IDLE) begin
            lcnt_n = '0;
        end else if ((state == DOWN || state == RELEASE_WAIT) && lcnt != LONG_MAX) begin
            lcnt_n = lcnt + 1'b1;
            long_n = (lcnt_n == LONG_MAX);
        end
    end
`else
    assign long_pulse = 1'b0;
`endif

endmodule

// File: tb/tb_button_debouncer.sv
// Directed self-checking bench for button_debouncer (DB_CYCLES=4, LONG_CYCLES=20, active-low pin).
module tb_button_debouncer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       btn;
    logic       pressed, press_pulse, release_pulse, long_pulse;
    logic [7:0] press_count;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    button_debouncer #(
        .CLK_HZ     (1000),
        .DEBOUNCE_MS(4),
        .LONG_MS    (20),
        .ACTIVE_LOW (1)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .btn          (btn),
        .pressed      (pressed),
        .press_pulse  (press_pulse),
        .release_pulse(release_pulse),
        .long_pulse   (long_pulse),
        .press_count  (press_count)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expect the chosen strobe low for n-1 cycles, high on cycle n, low again after.
    task automatic expect_strobe(input string tag, input bit rel, input int n);
        for (int i = 1; i < n; i++) begin
            tick();
            check({tag, "_early"}, rel ? release_pulse : press_pulse, 0);
        end
        tick();
        check(tag, rel ? release_pulse : press_pulse, 1);
        check({tag, "_level"}, pressed, rel ? 0 : 1);
        tick();
        check({tag, "_one_cycle"}, rel ? release_pulse : press_pulse, 0);
    endtask

    task automatic wait_press(input string tag);
        int k;
        k = 0;
        while (press_pulse !== 1'b1 && k < 20) begin
            tick();
            k++;
        end
        check({tag, "_press_seen"}, press_pulse, 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int seen, nlong, at, npress, nboth;
        logic [7:0] ecount;

        // Reset with button idle (high)
        rst_n = 1'b0;
        btn   = 1'b1;
        tick();
        tick();
        check("rst_outputs", {pressed, press_pulse, release_pulse, long_pulse}, 0);
        check("rst_count", press_count, 0);
        rst_n = 1'b1;
        for (int i = 0; i < 50; i++) begin
            tick();
            check("idle_outputs", {pressed, press_pulse, release_pulse, long_pulse, press_count}, 0);
        end

        // Clean press and release
        btn = 1'b0;
        expect_strobe("press", 1'b0, 7);
        check("press_count1", press_count, 1);
        btn = 1'b1;
        expect_strobe("release", 1'b1, 7);
        check("release_count", press_count, 1);

        // Press, then 2-cycle release glitch must be ignored
        btn = 1'b0;
        expect_strobe("press2", 1'b0, 7);
        check("press_count2", press_count, 2);
        repeat (3) tick();
        btn = 1'b1;
        tick();
        tick();
        btn  = 1'b0;
        seen = 0;
        for (int i = 0; i < 15; i++) begin
            tick();
            if (release_pulse !== 1'b0 || pressed !== 1'b1) seen++;
        end
        check("glitch_no_release", seen, 0);
        btn = 1'b1;
        expect_strobe("release2", 1'b1, 7);

        // Press bounce: low 3, high 1, low held
        btn = 1'b0;
        seen = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (press_pulse !== 1'b0) seen++;
        end
        btn = 1'b1;
        tick();
        if (press_pulse !== 1'b0) seen++;
        check("bounce_no_early", seen, 0);
        btn = 1'b0;
        expect_strobe("bounce_press", 1'b0, 7);
        check("bounce_count", press_count, 3);
        btn = 1'b1;
        expect_strobe("release3", 1'b1, 7);

        // 256 press/release cycles: counter wraps back to its start value
        ecount = 8'd3;
        npress = 0;
        nboth  = 0;
        for (int c = 0; c < 256; c++) begin
            btn = 1'b0;
            for (int i = 0; i < 10; i++) begin
                tick();
                if (press_pulse && release_pulse) nboth++;
                if (press_pulse === 1'b1) begin
                    npress++;
                    ecount = ecount + 8'd1;
                    check("wrap_count", press_count, ecount);
                end
            end
            btn = 1'b1;
            for (int i = 0; i < 10; i++) begin
                tick();
                if (press_pulse && release_pulse) nboth++;
            end
        end
        check("wrap_strobes", npress, 256);
        check("wrap_final", press_count, 3);
        check("wrap_no_overlap", nboth, 0);

        // Long press
        btn = 1'b0;
        wait_press("long");
        nlong = 0;
        at    = 0;
        for (int k = 1; k <= 30; k++) begin
            tick();
            if (long_pulse === 1'b1) begin
                nlong++;
                at = k;
            end
        end
`ifdef BUTTON_LONG_PRESS_EN
        check("long_count", nlong, 1);
        check("long_delay", at, 20);
`else
        check("long_disabled", nlong, 0);
`endif
        check("long_still_pressed", pressed, 1);
        btn = 1'b1;
        expect_strobe("long_release", 1'b1, 7);

        // Reset mid-hold: outputs clear at once, no release strobe
        btn = 1'b0;
        wait_press("hold");
        repeat (10) tick();
        rst_n = 1'b0;
        #1;
        check("midhold_rst_outputs", {pressed, press_pulse, release_pulse, long_pulse}, 0);
        check("midhold_rst_count", press_count, 0);
        seen = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (release_pulse !== 1'b0 || pressed !== 1'b0) seen++;
        end
        check("midhold_no_release", seen, 0);
        rst_n = 1'b1;
        expect_strobe("press_after_rst", 1'b0, 7);
        check("press_after_rst_count", press_count, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
